// File: rtl/prog_loader_pkg.sv
// Shared definitions for the serial program loader.
//   - frame and UART receiver state encodings
//   - frame sync byte and default instruction-memory depth
package prog_loader_pkg;

  localparam logic [7:0] SYNC_BYTE         = 8'hA5;
  localparam int         MEM_DEPTH_DEFAULT = 24;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_CHK
  } frame_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

endpackage

// File: rtl/prog_loader_uart_rx.sv
// 8N1 UART receiver.
//   clk        : system clock
//   rst        : synchronous active-high reset
//   rx         : asynchronous serial line, idle high
//   byte_valid : one-cycle pulse, byte_data holds a good byte
//   byte_data  : received byte (LSB first on the wire)
//   frame_err  : one-cycle pulse when the stop bit reads 0
module uart_rx
  import prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  logic            rx_meta_q, rx_s_q;
  rx_state_e       state_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic            byte_valid_q, frame_err_q;
  logic [7:0]      byte_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      state_q      <= RX_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      byte_data_q  <= '0;
    end else begin
      rx_meta_q    <= rx;
      rx_s_q       <= rx_meta_q;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          // Idle is only entered with the line high, so a low level here is the falling edge.
          if (!rx_s_q) begin
            cnt_q   <= '0;
            state_q <= RX_START;
          end
        end
        RX_START: begin
          if (cnt_q == HALF) begin
            cnt_q <= '0;
            bit_q <= '0;
            state_q <= rx_s_q ? RX_IDLE : RX_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt_q == FULL) begin
            cnt_q   <= '0;
            shift_q <= {rx_s_q, shift_q[7:1]};
            if (bit_q == 3'd7) state_q <= RX_STOP;
            else               bit_q   <= bit_q + 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt_q == FULL) begin
            cnt_q <= '0;
            if (rx_s_q) begin
              byte_valid_q <= 1'b1;
              byte_data_q  <= shift_q;
              state_q      <= RX_IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= RX_WAIT_HIGH;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_WAIT_HIGH: begin
          if (rx_s_q) state_q <= RX_IDLE;
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign byte_valid = byte_valid_q;
  assign byte_data  = byte_data_q;
  assign frame_err  = frame_err_q;

endmodule

// File: rtl/prog_loader.sv
// Serial program loader: receives A5/LEN/data/CHK frames over UART and
// writes the data bytes into CPU instruction memory, holding the CPU
// until a frame with a correct checksum has been loaded.
//   clk, rst          : clock, synchronous active-high reset
//   rx                : UART line (8N1, idle high)
//   prog_we/addr/data : one-cycle instruction-memory write, zero otherwise
//   cpu_run           : 1 releases the CPU
//   load_ok/load_err  : sticky status of the last frame
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int MEM_DEPTH    = MEM_DEPTH_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       prog_we,
  output logic [4:0] prog_addr,
  output logic [7:0] prog_data,
  output logic       cpu_run,
  output logic       load_ok,
  output logic       load_err
);

  localparam logic [7:0] MAX_LEN = 8'(MEM_DEPTH);

  logic       byte_valid, frame_err;
  logic [7:0] byte_data;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err)
  );

  frame_state_e state_q;
  logic [4:0]   len_q, idx_q;
  logic [7:0]   chk_q;
  logic         prog_we_q, cpu_run_q, load_ok_q, load_err_q;
  logic [4:0]   prog_addr_q;
  logic [7:0]   prog_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      idx_q       <= '0;
      chk_q       <= '0;
      prog_we_q   <= 1'b0;
      prog_addr_q <= '0;
      prog_data_q <= '0;
      cpu_run_q   <= 1'b0;
      load_ok_q   <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      prog_we_q   <= 1'b0;
      prog_addr_q <= '0;
      prog_data_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (byte_valid && byte_data == SYNC_BYTE) begin
            state_q    <= ST_LEN;
            load_ok_q  <= 1'b0;
            load_err_q <= 1'b0;
            cpu_run_q  <= 1'b0;
          end
        end
        ST_LEN: begin
          if (frame_err) begin
            load_err_q <= 1'b1;
            state_q    <= ST_IDLE;
          end else if (byte_valid) begin
            if (byte_data != 8'd0 && byte_data <= MAX_LEN) begin
              len_q   <= byte_data[4:0];
              chk_q   <= byte_data;
              idx_q   <= '0;
              state_q <= ST_DATA;
            end else begin
              load_err_q <= 1'b1;
              state_q    <= ST_IDLE;
            end
          end
        end
        ST_DATA: begin
          if (frame_err) begin
            load_err_q <= 1'b1;
            state_q    <= ST_IDLE;
          end else if (byte_valid) begin
            prog_we_q   <= 1'b1;
            prog_addr_q <= idx_q;
            prog_data_q <= byte_data;
            chk_q       <= chk_q ^ byte_data;
            idx_q       <= idx_q + 5'd1;
            if (idx_q + 5'd1 == len_q) state_q <= ST_CHK;
          end
        end
        ST_CHK: begin
          if (frame_err) begin
            load_err_q <= 1'b1;
            state_q    <= ST_IDLE;
          end else if (byte_valid) begin
            if (byte_data == chk_q) begin
              load_ok_q <= 1'b1;
              cpu_run_q <= 1'b1;
            end else begin
              load_err_q <= 1'b1;
            end
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign prog_we   = prog_we_q;
  assign prog_addr = prog_addr_q;
  assign prog_data = prog_data_q;
  assign cpu_run   = cpu_run_q;
  assign load_ok   = load_ok_q;
  assign load_err  = load_err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: drives UART frames on rx and checks the
// instruction-memory writes and status flags against hand-computed values.
module tb_prog_loader;

  localparam int CPB   = 16;
  localparam int DEPTH = 24;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       prog_we;
  logic [4:0] prog_addr;
  logic [7:0] prog_data;
  logic       cpu_run, load_ok, load_err;

  int n_vec = 0;
  int n_mis = 0;
  int idle_bad = 0;
  int dbl_we = 0;
  logic prev_we = 1'b0;
  logic [12:0] wq[$];

  always #5 clk = ~clk;

  prog_loader #(.CLKS_PER_BIT(CPB), .MEM_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .cpu_run   (cpu_run),
    .load_ok   (load_ok),
    .load_err  (load_err)
  );

  // Write monitor: records every strobe, flags non-zero bus while idle and back-to-back strobes.
  always @(negedge clk) begin
    if (prog_we === 1'b1) begin
      wq.push_back({prog_addr, prog_data});
      if (prev_we === 1'b1) dbl_we++;
    end else if (!rst && (prog_addr !== 5'd0 || prog_data !== 8'd0)) begin
      idle_bad++;
    end
    prev_we = prog_we;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Bytes packed MSB-first: the leftmost byte goes out first.
  task automatic send_frame(input logic [63:0] bytes, input int n);
    for (int i = 0; i < n; i++) send_byte(bytes[8*(n-1-i) +: 8], 1'b1);
    repeat (4) @(negedge clk);
  endtask

  // Expected writes packed MSB-first as {addr[4:0], data[7:0]}.
  task automatic expect_writes(input string tag, input logic [51:0] exp, input int n);
    check({tag, " nwr"}, wq.size(), n);
    for (int i = 0; i < n && i < wq.size(); i++)
      check($sformatf("%s wr%0d", tag, i), wq[i], exp[13*(n-1-i) +: 13]);
    wq.delete();
  endtask

  task automatic expect_flags(input string tag, input logic ok, input logic err, input logic run);
    check({tag, " ok/err/run"}, {load_ok, load_err, cpu_run}, {ok, err, run});
  endtask

  task automatic pulse_rst(input string tag);
    rst = 1'b1;
    @(negedge clk);
    check({tag, " outs"}, {prog_we, prog_addr, prog_data, load_ok, load_err, cpu_run}, '0);
    rst = 1'b0;
    @(negedge clk);
    wq.delete();
  endtask

  initial begin
    logic [7:0] chk;
    logic [7:0] d;
    logic [12:0] mexp[$];

    // Reset state
    repeat (3) @(negedge clk);
    check("rst we", prog_we, 1'b0);
    check("rst addr", prog_addr, 5'd0);
    check("rst data", prog_data, 8'd0);
    check("rst run", cpu_run, 1'b0);
    check("rst ok", load_ok, 1'b0);
    check("rst err", load_err, 1'b0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    wq.delete();

    // Good frame: chk = 03^01^05^0A = 0D
    send_frame({8'hA5, 8'h03, 8'h01, 8'h05, 8'h0A, 8'h0D}, 6);
    expect_writes("goodA", {5'd0, 8'h01, 5'd1, 8'h05, 5'd2, 8'h0A}, 3);
    expect_flags("goodA", 1'b1, 1'b0, 1'b1);

    // Reset clears sticky ok / run
    pulse_rst("rst_after_ok");

    // Same frame with wrong checksum 0F
    send_frame({8'hA5, 8'h03, 8'h01, 8'h05, 8'h0A, 8'h0F}, 6);
    expect_writes("badchk", {5'd0, 8'h01, 5'd1, 8'h05, 5'd2, 8'h0A}, 3);
    expect_flags("badchk", 1'b0, 1'b1, 1'b0);

    // Reset clears sticky err
    pulse_rst("rst_after_err");

    send_frame({8'hA5, 8'h03, 8'h01, 8'h05, 8'h0A, 8'h0D}, 6);
    expect_writes("goodA2", {5'd0, 8'h01, 5'd1, 8'h05, 5'd2, 8'h0A}, 3);
    expect_flags("goodA2", 1'b1, 1'b0, 1'b1);

    // Two-byte frame, checksum 02^01^05=06 != 00: ok cleared, err set
    send_frame({8'hA5, 8'h02, 8'h01, 8'h05, 8'h00}, 5);
    expect_writes("frameB", {5'd0, 8'h01, 5'd1, 8'h05}, 2);
    expect_flags("frameB", 1'b0, 1'b1, 1'b0);

    // LEN = 0
    send_frame({8'hA5, 8'h00}, 2);
    expect_writes("len0", '0, 0);
    expect_flags("len0", 1'b0, 1'b1, 1'b0);
    send_frame({8'hA5, 8'h01, 8'h3C, 8'h3D}, 4);
    expect_writes("len0_next", {5'd0, 8'h3C}, 1);
    expect_flags("len0_next", 1'b1, 1'b0, 1'b1);

    // LEN = 25, one past depth
    send_frame({8'hA5, 8'h19}, 2);
    expect_writes("len25", '0, 0);
    expect_flags("len25", 1'b0, 1'b1, 1'b0);

    // LEN = 24, full depth: addresses 0..23
    send_byte(8'hA5, 1'b1);
    send_byte(8'h18, 1'b1);
    chk = 8'h18;
    for (int i = 0; i < DEPTH; i++) begin
      d = 8'(i * 7 + 3);
      chk = chk ^ d;
      mexp.push_back({5'(i), d});
      send_byte(d, 1'b1);
    end
    send_byte(chk, 1'b1);
    repeat (4) @(negedge clk);
    check("len24 nwr", wq.size(), DEPTH);
    for (int i = 0; i < DEPTH && i < wq.size(); i++)
      check($sformatf("len24 wr%0d", i), wq[i], mexp[i]);
    wq.delete();
    expect_flags("len24", 1'b1, 1'b0, 1'b1);

    // Framing error while idle is ignored
    send_byte(8'h5A, 1'b0);
    repeat (4) @(negedge clk);
    expect_writes("ferr_idle", '0, 0);
    expect_flags("ferr_idle", 1'b1, 1'b0, 1'b1);

    // Stop bit 0 on second data byte
    send_byte(8'hA5, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    repeat (4) @(negedge clk);
    expect_writes("ferr_data", {5'd0, 8'h11}, 1);
    expect_flags("ferr_data", 1'b0, 1'b1, 1'b0);

    // Short low glitch on idle line (shorter than half a bit)
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    expect_writes("glitch", '0, 0);
    expect_flags("glitch", 1'b0, 1'b1, 1'b0);

    // 02^10^20 = 32
    send_frame({8'hA5, 8'h02, 8'h10, 8'h20, 8'h32}, 5);
    expect_writes("post_glitch", {5'd0, 8'h10, 5'd1, 8'h20}, 2);
    expect_flags("post_glitch", 1'b1, 1'b0, 1'b1);

    // Reset mid-DATA after one of three bytes; rest of frame must be ignored
    send_byte(8'hA5, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h01, 1'b1);
    check("mid nwr", wq.size(), 1);
    pulse_rst("rst_mid");
    send_frame({8'h05, 8'h0A, 8'h0D}, 3);
    expect_writes("abandoned", '0, 0);
    expect_flags("abandoned", 1'b0, 1'b0, 1'b0);

    // Garbage then a frame whose data byte equals the sync byte
    send_frame({8'h11, 8'h22, 8'hA5, 8'h01, 8'hA5, 8'hA4}, 6);
    expect_writes("garbage", {5'd0, 8'hA5}, 1);
    expect_flags("garbage", 1'b1, 1'b0, 1'b1);

    check("idle bus zero", idle_bad, 0);
    check("single-cycle we", dbl_we, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
